centrosym_stream_transform: RTL and testbench

- Streaming, N-antenna generalisation of the centrosymmetric unitary transform y = Q^H x used ahead of the real-valued correlation in the unitary-ESPRIT DoA chain.
- Accepts one complex antenna sample per cycle, framed N samples per snapshot.
- Buffers each snapshot in a ping-pong register bank and emits N transformed samples serially.
- Checks frame length and drops malformed snapshots.

---
 rtl/centrosym_stream_transform_pkg.sv | 23 ++
 rtl/centrosym_stream_transform_if.sv | 39 +++
 rtl/centrosym_stream_transform_butterfly.sv | 73 +++++++
 rtl/centrosym_stream_transform.sv | 179 +++++++++++++++++
 tb/tb_centrosym_stream_transform.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/centrosym_stream_transform_pkg.sv
// Shared definitions for the centrosymmetric stream transform.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package centrosym_stream_transform_pkg;

    // Read sequencer states.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // The transform pairs antenna k with antenna N-1-k, so the array must be
    // even-sized with at least one pair.
    function automatic bit n_ant_ok(input int n);
        return (n >= 2) && ((n % 2) == 0);
    endfunction

    // A sum or difference of two DIN-bit signed values needs one extra bit.
    function automatic int out_width(input int din_width);
        return din_width + 1;
    endfunction

endpackage

// File: rtl/centrosym_stream_transform_if.sv
// Sample-in / transformed-sample-out bundle for the centrosymmetric transform.
// Latency: n/a (wiring only).
// Backpressure: none; both directions are valid-only streams.
// Ports: din_re/din_im/din_valid/din_last (source -> block),
//        dout_re/dout_im/dout_valid/dout_idx/dout_last/frame_err (block -> sink).
interface centrosym_stream_transform_if
    import centrosym_stream_transform_pkg::*;
#(
    parameter int DIN_WIDTH = 18,
    parameter int N_ANT     = 4
);
    localparam int DOUT_WIDTH = out_width(DIN_WIDTH);
    localparam int IDX_WIDTH  = $clog2(N_ANT);

    logic signed [DIN_WIDTH-1:0]  din_re;
    logic signed [DIN_WIDTH-1:0]  din_im;
    logic                         din_valid;
    logic                         din_last;

    logic signed [DOUT_WIDTH-1:0] dout_re;
    logic signed [DOUT_WIDTH-1:0] dout_im;
    logic                         dout_valid;
    logic [IDX_WIDTH-1:0]         dout_idx;
    logic                         dout_last;
    logic                         frame_err;

    // master: sample source / result sink (testbench or upstream block).
    modport master (
        output din_re, din_im, din_valid, din_last,
        input  dout_re, dout_im, dout_valid, dout_idx, dout_last, frame_err
    );

    // slave: the transform block itself.
    modport slave (
        input  din_re, din_im, din_valid, din_last,
        output dout_re, dout_im, dout_valid, dout_idx, dout_last, frame_err
    );

endinterface

// File: rtl/centrosym_stream_transform_butterfly.sv
// Centrosymmetric butterfly: p+q for the upper half, -j*(p-q) for the lower half.
// Latency: 1 cycle (result registered).
// Backpressure: none; accepts one operand pair per cycle when in_valid.
// Ports: p_*/q_* operands, sel (0 = sum, 1 = rotated difference), in_valid/idx/last
//        side-band, out_* registered result with side-band aligned to it.
module centrosym_stream_transform_butterfly
    import centrosym_stream_transform_pkg::*;
#(
    parameter int DIN_WIDTH = 18,
    parameter int IDX_WIDTH = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic signed [DIN_WIDTH-1:0]            p_re,
    input  logic signed [DIN_WIDTH-1:0]            p_im,
    input  logic signed [DIN_WIDTH-1:0]            q_re,
    input  logic signed [DIN_WIDTH-1:0]            q_im,
    input  logic                                   sel,
    input  logic                                   in_valid,
    input  logic [IDX_WIDTH-1:0]                   in_idx,
    input  logic                                   in_last,
    output logic signed [out_width(DIN_WIDTH)-1:0] out_re,
    output logic signed [out_width(DIN_WIDTH)-1:0] out_im,
    output logic                                   out_valid,
    output logic [IDX_WIDTH-1:0]                   out_idx,
    output logic                                   out_last
);
    localparam int OW = out_width(DIN_WIDTH);

    logic signed [OW-1:0] p_re_x;
    logic signed [OW-1:0] p_im_x;
    logic signed [OW-1:0] q_re_x;
    logic signed [OW-1:0] q_im_x;
    logic signed [OW-1:0] res_re;
    logic signed [OW-1:0] res_im;

    always_comb begin
        // Widen before the add/sub so the result is exact.
        p_re_x = OW'(p_re);
        p_im_x = OW'(p_im);
        q_re_x = OW'(q_re);
        q_im_x = OW'(q_im);
        if (sel) begin
            // -j*(p-q): real part takes the imaginary difference, imaginary
            // part takes the negated real difference.
            res_re = p_im_x - q_im_x;
            res_im = q_re_x - p_re_x;
        end else begin
            res_re = p_re_x + q_re_x;
            res_im = p_im_x + q_im_x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_re    <= '0;
            out_im    <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_last  <= in_valid & in_last;
            // Data and index hold between bursts.
            if (in_valid) begin
                out_re  <= res_re;
                out_im  <= res_im;
                out_idx <= in_idx;
            end
        end
    end

endmodule

// File: rtl/centrosym_stream_transform.sv
// Streaming N-antenna centrosymmetric unitary transform (unnormalised Q^H x).
// Latency: row 0 valid on the 3rd rising edge after din_last is accepted.
// Backpressure: none; ping-pong banks guarantee the write bank is always free.
// Ports: clk, rst_n (async active-low), bus (slave modport: din_* in, dout_*/frame_err out).
module centrosym_stream_transform
    import centrosym_stream_transform_pkg::*;
#(
    parameter int DIN_WIDTH = 18,
    parameter int N_ANT     = 4,
    parameter int IDX_WIDTH = $clog2(N_ANT)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    centrosym_stream_transform_if.slave  bus
);
    if (!n_ant_ok(N_ANT)) begin : g_bad_n_ant
        $error("centrosym_stream_transform: N_ANT must be even and >= 2");
    end

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_ANT - 1);
    localparam logic [IDX_WIDTH-1:0] HALF_IDX = IDX_WIDTH'(N_ANT / 2);
    localparam logic [IDX_WIDTH-1:0] ONE_IDX  = IDX_WIDTH'(1);

    // Ping-pong snapshot storage, data only (no reset needed).
    logic signed [DIN_WIDTH-1:0] bank_re [2][N_ANT];
    logic signed [DIN_WIDTH-1:0] bank_im [2][N_ANT];

    // Write side control.
    logic [IDX_WIDTH-1:0] wcnt;
    logic                 wbank;
    logic [1:0]           full;
    logic [1:0]           full_nxt;
    logic                 frame_err_q;

    // Read sequencer.
    seq_state_t           state;
    logic                 rbank;
    logic [IDX_WIDTH-1:0] ridx;

    // Operand stage feeding the butterfly.
    logic                        s1_vld;
    logic                        s1_sel;
    logic [IDX_WIDTH-1:0]        s1_idx;
    logic                        s1_last;
    logic signed [DIN_WIDTH-1:0] s1_p_re;
    logic signed [DIN_WIDTH-1:0] s1_p_im;
    logic signed [DIN_WIDTH-1:0] s1_q_re;
    logic signed [DIN_WIDTH-1:0] s1_q_im;

    logic                 wr_done;
    logic                 wr_err;
    logic                 rd_free;
    logic                 rd_sel;
    logic [IDX_WIDTH-1:0] rd_k;
    logic [IDX_WIDTH-1:0] rd_qk;

    always_comb begin
        wr_done  = bus.din_valid && (wcnt == LAST_IDX) && bus.din_last;
        // din_last and the final slot must coincide; either alone is malformed.
        wr_err   = bus.din_valid && ((wcnt == LAST_IDX) != bus.din_last);
        rd_free  = (state == RUN) && (ridx == LAST_IDX);

        // Clear before set: a bank freed this cycle may be refilled this cycle.
        full_nxt = full;
        if (rd_free) begin
            full_nxt[rbank] = 1'b0;
        end
        if (wr_done) begin
            full_nxt[wbank] = 1'b1;
        end

        // Rows 0..M-1 use antenna ridx, rows M..N-1 reuse antennas 0..M-1.
        rd_sel = (ridx >= HALF_IDX);
        rd_k   = rd_sel ? (ridx - HALF_IDX) : ridx;
        rd_qk  = LAST_IDX - rd_k;
    end

    always_ff @(posedge clk) begin
        if (bus.din_valid) begin
            bank_re[wbank][wcnt] <= bus.din_re;
            bank_im[wbank][wcnt] <= bus.din_im;
        end
    end

    always_ff @(posedge clk) begin
        if (state == RUN) begin
            s1_p_re <= bank_re[rbank][rd_k];
            s1_p_im <= bank_im[rbank][rd_k];
            s1_q_re <= bank_re[rbank][rd_qk];
            s1_q_im <= bank_im[rbank][rd_qk];
        end
    end

    // Write counter, bank flags and the read sequencer share one block since
    // both sides update the full flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt        <= '0;
            wbank       <= 1'b0;
            full        <= '0;
            frame_err_q <= 1'b0;
            state       <= IDLE;
            rbank       <= 1'b0;
            ridx        <= '0;
            s1_vld      <= 1'b0;
            s1_sel      <= 1'b0;
            s1_idx      <= '0;
            s1_last     <= 1'b0;
        end else begin
            full        <= full_nxt;
            frame_err_q <= wr_err;

            if (bus.din_valid) begin
                if (wr_done) begin
                    wbank <= ~wbank;
                    wcnt  <= '0;
                end else if (wr_err) begin
                    wcnt  <= '0;
                end else begin
                    wcnt  <= wcnt + ONE_IDX;
                end
            end

            s1_vld  <= (state == RUN);
            s1_sel  <= rd_sel;
            s1_idx  <= ridx;
            s1_last <= (ridx == LAST_IDX);

            case (state)
                IDLE: begin
                    ridx <= '0;
                    if (full[rbank]) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (ridx == LAST_IDX) begin
                        rbank <= ~rbank;
                        ridx  <= '0;
                        // Chain straight into the other bank if it is ready.
                        if (!full[~rbank]) begin
                            state <= IDLE;
                        end
                    end else begin
                        ridx <= ridx + ONE_IDX;
                    end
                end
                default: begin
                    state <= IDLE;
                    ridx  <= '0;
                end
            endcase
        end
    end

    assign bus.frame_err = frame_err_q;

    centrosym_stream_transform_butterfly #(
        .DIN_WIDTH (DIN_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_butterfly (
        .clk       (clk),
        .rst_n     (rst_n),
        .p_re      (s1_p_re),
        .p_im      (s1_p_im),
        .q_re      (s1_q_re),
        .q_im      (s1_q_im),
        .sel       (s1_sel),
        .in_valid  (s1_vld),
        .in_idx    (s1_idx),
        .in_last   (s1_last),
        .out_re    (bus.dout_re),
        .out_im    (bus.dout_im),
        .out_valid (bus.dout_valid),
        .out_idx   (bus.dout_idx),
        .out_last  (bus.dout_last)
    );

endmodule

// File: tb/tb_centrosym_stream_transform.sv
// Randomised scoreboard bench for centrosym_stream_transform (N_ANT=4, DIN_WIDTH=18).
module tb_centrosym_stream_transform;
    localparam int DW = 18;
    localparam int N  = 4;
    localparam int M  = N / 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    centrosym_stream_transform_if #(.DIN_WIDTH(DW), .N_ANT(N)) bus ();

    centrosym_stream_transform #(.DIN_WIDTH(DW), .N_ANT(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int re;
        int im;
        int idx;
        int last;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    int   smp_re[$];
    int   smp_im[$];
    int   obs_re[$];
    int   obs_im[$];
    int   last_start = -1000;
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: collect samples of a frame; a frame is good only when
    // din_last lands on the N-th sample. Output burst starts 3 edges after the
    // last sample, but never before the previous burst has finished.
    function automatic void model_accept(input int re, input int im, input bit last, input int acc);
        int   st;
        int   k;
        exp_t e;
        smp_re.push_back(re);
        smp_im.push_back(im);
        if (last && smp_re.size() == N) begin
            st = (acc + 3 > last_start + N) ? acc + 3 : last_start + N;
            last_start = st;
            for (int r = 0; r < N; r++) begin
                k = (r < M) ? r : r - M;
                if (r < M) begin
                    e.re = smp_re[k] + smp_re[N-1-k];
                    e.im = smp_im[k] + smp_im[N-1-k];
                end else begin
                    e.re = smp_im[k] - smp_im[N-1-k];
                    e.im = smp_re[N-1-k] - smp_re[k];
                end
                e.idx  = r;
                e.last = (r == N - 1) ? 1 : 0;
                e.cyc  = st + r;
                exp_q.push_back(e);
            end
            smp_re.delete();
            smp_im.delete();
        end else if (last || smp_re.size() == N) begin
            err_q.push_back(acc);
            smp_re.delete();
            smp_im.delete();
        end
    endfunction

    task automatic drive(input int re, input int im, input bit last);
        int acc;
        bus.din_re    = DW'(re);
        bus.din_im    = DW'(im);
        bus.din_last  = last;
        bus.din_valid = 1'b1;
        acc = cyc + 1;
        @(posedge clk);
        model_accept(re, im, last, acc);
        #1;
        bus.din_valid = 1'b0;
        bus.din_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    task automatic rand_frame(input int max_gap);
        for (int i = 0; i < N; i++) begin
            drive(rnd_s(), rnd_s(), i == N - 1);
            if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic base_frame(input int gap);
        drive(1, 2, 1'b0);
        drive(3, 4, 1'b0);
        idle(gap);
        drive(5, 6, 1'b0);
        drive(7, 8, 1'b1);
    endtask

    task automatic check_base_obs(input string tag);
        check({tag, "_count"}, obs_re.size(), N);
        if (obs_re.size() == N) begin
            check({tag, "_idx0_re"}, obs_re[0], 8);
            check({tag, "_idx0_im"}, obs_im[0], 10);
            check({tag, "_idx1_re"}, obs_re[1], 8);
            check({tag, "_idx1_im"}, obs_im[1], 10);
            check({tag, "_idx2_re"}, obs_re[2], -6);
            check({tag, "_idx2_im"}, obs_im[2], 6);
            check({tag, "_idx3_re"}, obs_re[3], -2);
            check({tag, "_idx3_im"}, obs_im[3], 2);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dout_valid"}, int'(bus.dout_valid), 0);
        check({tag, "_dout_re"},    int'(bus.dout_re), 0);
        check({tag, "_dout_im"},    int'(bus.dout_im), 0);
        check({tag, "_dout_idx"},   int'(bus.dout_idx), 0);
        check({tag, "_dout_last"},  int'(bus.dout_last), 0);
        check({tag, "_frame_err"},  int'(bus.frame_err), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.dout_valid) begin
                obs_re.push_back(int'(bus.dout_re));
                obs_im.push_back(int'(bus.dout_im));
                if (exp_q.size() == 0) begin
                    check("unexpected_dout_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("dout_re",    int'(bus.dout_re), e.re);
                    check("dout_im",    int'(bus.dout_im), e.im);
                    check("dout_idx",   int'(bus.dout_idx), e.idx);
                    check("dout_last",  int'(bus.dout_last), e.last);
                    check("dout_cycle", cyc, e.cyc);
                end
            end
            if (bus.frame_err) begin
                if (err_q.size() == 0) check("unexpected_frame_err", 1, 0);
                else check("frame_err_cycle", cyc, err_q.pop_front());
            end
        end
    end

    initial begin
        int found;
        rst_n         = 1'b0;
        bus.din_re    = '0;
        bus.din_im    = '0;
        bus.din_valid = 1'b0;
        bus.din_last  = 1'b0;
        idle(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Reference frame, contiguous.
        obs_re.delete(); obs_im.delete();
        base_frame(0);
        idle(8);
        check_base_obs("base");

        // Two frames back-to-back: bursts must abut (checked via cycle stamps).
        rand_frame(0);
        rand_frame(0);
        idle(12);

        // Same reference frame with a 3-cycle hole between x1 and x2.
        obs_re.delete(); obs_im.delete();
        base_frame(3);
        idle(8);
        check_base_obs("gap");

        // Early din_last, then a good frame.
        drive(11, 12, 1'b0);
        drive(13, 14, 1'b0);
        drive(15, 16, 1'b1);
        rand_frame(0);
        idle(8);
        // Missing din_last on the 4th sample, then a good frame.
        for (int i = 0; i < N; i++) drive(rnd_s(), rnd_s(), 1'b0);
        rand_frame(1);
        idle(8);

        // Extremes.
        obs_re.delete(); obs_im.delete();
        drive(131071, 131071, 1'b0);
        drive(rnd_s(), rnd_s(), 1'b0);
        drive(rnd_s(), rnd_s(), 1'b0);
        drive(131071, 131071, 1'b1);
        drive(-131072, -131072, 1'b0);
        drive(rnd_s(), rnd_s(), 1'b0);
        drive(rnd_s(), rnd_s(), 1'b0);
        drive(131071, 131071, 1'b1);
        idle(12);
        check("extreme_count", obs_re.size(), 2 * N);
        if (obs_re.size() == 2 * N) begin
            check("extreme_sum_re", obs_re[0], 262142);
            check("extreme_sum_im", obs_im[0], 262142);
            check("extreme_diff_re", obs_re[N + 2], -262143);
            check("extreme_diff_im", obs_im[N + 2], 262143);
        end

        // Random traffic with occasional malformed frames.
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 7))
                0: begin
                    int len;
                    len = int'($urandom_range(1, N - 1));
                    for (int i = 0; i < len; i++) drive(rnd_s(), rnd_s(), i == len - 1);
                end
                1: for (int i = 0; i < N; i++) drive(rnd_s(), rnd_s(), 1'b0);
                default: rand_frame(2);
            endcase
            idle(int'($urandom_range(0, 3)));
        end
        idle(12);

        // Reset in the middle of a burst while the other bank is also full.
        rand_frame(0);
        rand_frame(0);
        found = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            #1;
            if (bus.dout_valid && bus.dout_idx == 2'd1) begin
                found = 1;
                break;
            end
        end
        check("reset_mid_burst_reached", found, 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        exp_q.delete();
        err_q.delete();
        smp_re.delete();
        smp_im.delete();
        last_start = -1000;
        idle(2);
        rst_n = 1'b1;
        obs_re.delete(); obs_im.delete();
        idle(2);
        base_frame(0);
        idle(10);
        check_base_obs("after_reset");

        // Drain and confirm nothing is still owed.
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(posedge clk);
        idle(4);
        check("exp_queue_drained", exp_q.size(), 0);
        check("err_queue_drained", err_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
